// File: rtl/host_cmd_decoder_pkg.sv
// Shared definitions for the host command decoder: opcodes, reply codes,
// FSM state encoding and the opcode decode helper.
package host_cmd_decoder_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1048576;

    // Host command bytes (ASCII)
    localparam logic [7:0] OP_START = 8'h73;  // 's'
    localparam logic [7:0] OP_STOP  = 8'h78;  // 'x'
    localparam logic [7:0] OP_READ  = 8'h72;  // 'r'
    localparam logic [7:0] OP_WRITE = 8'h77;  // 'w' + 1 arg
    localparam logic [7:0] OP_DELAY = 8'h64;  // 'd' + 1 arg
    localparam logic [7:0] OP_ECHO  = 8'h65;  // 'e' + 1 arg

    // Reply bytes (ASCII)
    localparam logic [7:0] REPLY_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] REPLY_UNKNOWN = 8'h3F;  // '?'
    localparam logic [7:0] REPLY_ERROR   = 8'h21;  // '!'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ARG,
        ST_ISSUE,
        ST_STROBE,
        ST_WAIT_DONE,
        ST_SEND
    } state_t;

    // Command index; doubles as the bit position of its strobe
    typedef enum logic [2:0] {
        CMD_START = 3'd0,
        CMD_STOP  = 3'd1,
        CMD_READ  = 3'd2,
        CMD_WRITE = 3'd3,
        CMD_DELAY = 3'd4,
        CMD_ECHO  = 3'd5
    } cmd_t;

    typedef struct packed {
        logic valid;
        logic has_arg;
        cmd_t cmd;
    } op_decode_t;

    function automatic op_decode_t decode_op(input logic [7:0] b);
        op_decode_t d;
        d.valid   = 1'b1;
        d.has_arg = 1'b0;
        d.cmd     = CMD_START;
        case (b)
            OP_START: d.cmd = CMD_START;
            OP_STOP:  d.cmd = CMD_STOP;
            OP_READ:  d.cmd = CMD_READ;
            OP_WRITE: begin d.cmd = CMD_WRITE; d.has_arg = 1'b1; end
            OP_DELAY: begin d.cmd = CMD_DELAY; d.has_arg = 1'b1; end
            OP_ECHO:  begin d.cmd = CMD_ECHO;  d.has_arg = 1'b1; end
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Commands whose reply is the byte returned by the BDM controller
    function automatic logic returns_data(input cmd_t c);
        return (c == CMD_READ) || (c == CMD_ECHO);
    endfunction

endpackage

// File: rtl/host_cmd_decoder_if.sv
// Host UART + BDM controller signal bundle for the command decoder.
// slave: the decoder side; master: the host/BDM side driving it.
interface host_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       do_start_mcu;
    logic       do_stop_mcu;
    logic       do_read;
    logic       do_write;
    logic       do_delay;
    logic       do_echo_test;
    logic [7:0] cmd_data;
    logic       bdm_ready;
    logic       bdm_valid;
    logic [7:0] bdm_data;
    logic       overrun;
    logic       busy;

    modport slave (
        input  rx_data, rx_valid, tx_busy, bdm_ready, bdm_valid, bdm_data,
        output tx_data, tx_start, do_start_mcu, do_stop_mcu, do_read, do_write,
               do_delay, do_echo_test, cmd_data, overrun, busy
    );

    modport master (
        output rx_data, rx_valid, tx_busy, bdm_ready, bdm_valid, bdm_data,
        input  tx_data, tx_start, do_start_mcu, do_stop_mcu, do_read, do_write,
               do_delay, do_echo_test, cmd_data, overrun, busy
    );
endinterface

// File: rtl/host_cmd_decoder.sv
// Decodes single-byte host commands (optionally followed by one argument
// byte), hands them to the BDM controller as one-cycle strobes, waits for
// completion with a timeout, and returns a one-byte reply to the host.
module host_cmd_decoder
    import host_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    host_cmd_decoder_if.slave bus
);

    localparam int unsigned           CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q,     state_d;
    cmd_t             cmd_q,       cmd_d;
    logic [7:0]       cmd_data_q,  cmd_data_d;
    logic [7:0]       result_q,    result_d;
    logic             got_valid_q, got_valid_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [7:0]       tx_data_q,   tx_data_d;
    logic [5:0]       strobe_q,    strobe_d;
    logic             overrun_q,   overrun_d;

    logic [CNT_W-1:0] cnt_inc;
    op_decode_t       rx_dec;

    assign rx_dec  = decode_op(bus.rx_data);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, datapath and strobe generation
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_data_d  = cmd_data_q;
        result_d    = result_q;
        got_valid_d = got_valid_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        strobe_d    = '0;
        overrun_d   = overrun_q;

        // Bytes arriving while a command is in flight are dropped
        if (bus.rx_valid && (state_q != ST_IDLE) && (state_q != ST_GET_ARG)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (!rx_dec.valid) begin
                        tx_data_d = REPLY_UNKNOWN;
                        state_d   = ST_SEND;
                    end else begin
                        cmd_d   = rx_dec.cmd;
                        state_d = rx_dec.has_arg ? ST_GET_ARG : ST_ISSUE;
                    end
                end
            end
            ST_GET_ARG: begin
                if (bus.rx_valid) begin
                    cmd_data_d = bus.rx_data;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Strobe is loaded into a flop here so bdm_ready never
                // reaches the do_* outputs combinationally.
                if (bus.bdm_ready) begin
                    strobe_d[cmd_q] = 1'b1;
                    state_d         = ST_STROBE;
                end
            end
            ST_STROBE: begin
                cnt_d       = '0;
                got_valid_d = 1'b0;
                state_d     = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.bdm_valid) begin
                    result_d    = bus.bdm_data;
                    got_valid_d = 1'b1;
                end
                if (bus.bdm_ready) begin
                    state_d = ST_SEND;
                    if (returns_data(cmd_q)) begin
                        tx_data_d = (bus.bdm_valid || got_valid_q) ? result_d : REPLY_ERROR;
                    end else begin
                        tx_data_d = REPLY_OK;
                    end
                end else if (cnt_inc == CNT_MAX) begin
                    tx_data_d = REPLY_ERROR;
                    state_d   = ST_SEND;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_START;
            cmd_data_q  <= '0;
            result_q    <= '0;
            got_valid_q <= 1'b0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            strobe_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_data_q  <= cmd_data_d;
            result_q    <= result_d;
            got_valid_q <= got_valid_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            strobe_q    <= strobe_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.do_start_mcu = strobe_q[CMD_START];
    assign bus.do_stop_mcu  = strobe_q[CMD_STOP];
    assign bus.do_read      = strobe_q[CMD_READ];
    assign bus.do_write     = strobe_q[CMD_WRITE];
    assign bus.do_delay     = strobe_q[CMD_DELAY];
    assign bus.do_echo_test = strobe_q[CMD_ECHO];
    assign bus.cmd_data     = cmd_data_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_start     = (state_q == ST_SEND) && !bus.tx_busy;
    assign bus.overrun      = overrun_q;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_host_cmd_decoder.sv
// Scoreboard bench for host_cmd_decoder: directed host byte sequences push
// expected strobes/replies; a monitor pops and compares on every strobe or
// tx_start; a small BDM/UART-tx model answers the strobes.
module tb_host_cmd_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    host_cmd_decoder_if bus_if();

    host_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    localparam logic [5:0] V_START = 6'b000001;
    localparam logic [5:0] V_STOP  = 6'b000010;
    localparam logic [5:0] V_READ  = 6'b000100;
    localparam logic [5:0] V_WRITE = 6'b001000;
    localparam logic [5:0] V_DELAY = 6'b010000;
    localparam logic [5:0] V_ECHO  = 6'b100000;

    typedef struct {
        logic [5:0] vec;
        logic [7:0] cmd;
        bit         chk_cmd;
        int         at;
    } strobe_exp_t;

    typedef struct {
        logic [7:0] data;
        int         abs_cyc;
        int         rel_done;
    } reply_exp_t;

    strobe_exp_t sb_strobe[$];
    reply_exp_t  sb_reply[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // BDM model configuration (written by stimulus, read by model)
    int         cfg_work   = 3;
    bit         cfg_valid  = 1'b0;
    bit         cfg_echo   = 1'b0;
    bit         cfg_hold   = 1'b0;
    logic [7:0] cfg_data   = 8'h00;
    int         cfg_txbusy = 0;
    int         done_cyc   = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe / tx_start pops and checks one expectation
    always @(negedge clk) begin
        logic [5:0]  v;
        strobe_exp_t se;
        reply_exp_t  re;
        v = {bus_if.do_echo_test, bus_if.do_delay, bus_if.do_write,
             bus_if.do_read, bus_if.do_stop_mcu, bus_if.do_start_mcu};
        if (v != 6'b0) begin
            if (sb_strobe.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL strobe_unexpected actual=%b expected=none (cycle %0d)", v, cyc);
            end else begin
                se = sb_strobe.pop_front();
                check("strobe_vec", 32'(v), 32'(se.vec));
                if (se.chk_cmd) check("strobe_cmd_data", 32'(bus_if.cmd_data), 32'(se.cmd));
                if (se.at >= 0) check("strobe_cycle", cyc, se.at);
            end
        end
        if (bus_if.tx_start === 1'b1) begin
            if (sb_reply.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL reply_unexpected actual=%h expected=none (cycle %0d)", bus_if.tx_data, cyc);
            end else begin
                re = sb_reply.pop_front();
                check("reply_data", 32'(bus_if.tx_data), 32'(re.data));
                if (re.abs_cyc >= 0) check("reply_cycle", cyc, re.abs_cyc);
                if (re.rel_done >= 0) check("reply_latency", cyc - done_cyc, re.rel_done);
            end
        end
    end

    // BDM controller + UART transmitter model, updated just after each edge
    initial begin
        bit working;
        int wcnt;
        int txb;
        working = 1'b0;
        wcnt    = 0;
        txb     = 0;
        bus_if.bdm_ready = 1'b1;
        bus_if.bdm_valid = 1'b0;
        bus_if.bdm_data  = 8'h00;
        bus_if.tx_busy   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.bdm_valid = 1'b0;
            if (txb > 0) begin
                bus_if.tx_busy = 1'b1;
                txb--;
            end else begin
                bus_if.tx_busy = 1'b0;
            end
            if (!working) begin
                bus_if.bdm_ready = !cfg_hold;
                if ({bus_if.do_echo_test, bus_if.do_delay, bus_if.do_write,
                     bus_if.do_read, bus_if.do_stop_mcu, bus_if.do_start_mcu} != 6'b0) begin
                    working          = 1'b1;
                    wcnt             = cfg_work;
                    bus_if.bdm_ready = 1'b0;
                    bus_if.bdm_data  = cfg_echo ? bus_if.cmd_data : cfg_data;
                end
            end else if (wcnt < 0) begin
                if (cfg_work >= 0) working = 1'b0;
            end else if (wcnt > 1) begin
                wcnt--;
            end else begin
                working          = 1'b0;
                bus_if.bdm_ready = 1'b1;
                bus_if.bdm_valid = cfg_valid;
                done_cyc         = cyc;
                txb              = cfg_txbusy;
            end
        end
    end

    task automatic drive_byte(input logic [7:0] b, output int j);
        @(negedge clk);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        j = cyc;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_strobe(input logic [5:0] v, input logic [7:0] c, input bit chk, input int at);
        strobe_exp_t e;
        e = '{vec: v, cmd: c, chk_cmd: chk, at: at};
        sb_strobe.push_back(e);
    endtask

    task automatic exp_reply(input logic [7:0] d, input int abs_c, input int rel);
        reply_exp_t e;
        e = '{data: d, abs_cyc: abs_c, rel_done: rel};
        sb_reply.push_back(e);
    endtask

    // Directed stimulus
    initial begin
        int j, j1, j2, r;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        rst = 1'b1;
        wait_cyc(3);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_overrun", 32'(bus_if.overrun), 32'd0);
        check("rst_tx_start", 32'(bus_if.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus_if.tx_data), 32'h00);
        check("rst_cmd_data", 32'(bus_if.cmd_data), 32'h00);
        check("rst_strobes", 32'({bus_if.do_echo_test, bus_if.do_delay, bus_if.do_write,
                                  bus_if.do_read, bus_if.do_stop_mcu, bus_if.do_start_mcu}), 32'd0);
        rst = 1'b0;
        wait_cyc(2);

        // 's': strobe exactly two cycles after the rx_valid cycle, reply 'K'
        drive_byte(8'h73, j);
        exp_strobe(V_START, 8'h00, 1'b0, j + 2);
        exp_reply(8'h4B, -1, 1);
        drop_valid();
        wait_cyc(10);

        // Unknown byte 'A': no strobe, immediate '?'
        drive_byte(8'h41, j);
        exp_reply(8'h3F, j + 1, -1);
        drop_valid();
        wait_cyc(5);

        // 'w' 0xA3 with bdm_ready low for 10 cycles
        cfg_hold = 1'b1;
        wait_cyc(1);
        drive_byte(8'h77, j1);
        drop_valid();
        drive_byte(8'hA3, j2);
        drop_valid();
        wait_cyc(5);
        check("issue_waits_busy", 32'(bus_if.busy), 32'd1);
        r = cyc;
        exp_strobe(V_WRITE, 8'hA3, 1'b1, r + 2);
        exp_reply(8'h4B, -1, 1);
        cfg_hold = 1'b0;
        wait_cyc(10);

        // 'r' returning 0x3C, transmitter busy 5 cycles after completion
        cfg_valid  = 1'b1;
        cfg_data   = 8'h3C;
        cfg_txbusy = 5;
        wait_cyc(1);
        drive_byte(8'h72, j);
        exp_strobe(V_READ, 8'h00, 1'b0, j + 2);
        exp_reply(8'h3C, -1, 6);
        drop_valid();
        wait_cyc(15);
        cfg_txbusy = 0;

        // 'r' completing without bdm_valid: '!'
        cfg_valid = 1'b0;
        wait_cyc(1);
        drive_byte(8'h72, j);
        exp_strobe(V_READ, 8'h00, 1'b0, j + 2);
        exp_reply(8'h21, -1, 1);
        drop_valid();
        wait_cyc(10);

        // 'e' 0x5A echoed back by the model
        cfg_echo  = 1'b1;
        cfg_valid = 1'b1;
        wait_cyc(1);
        drive_byte(8'h65, j1);
        drop_valid();
        drive_byte(8'h5A, j2);
        exp_strobe(V_ECHO, 8'h5A, 1'b1, j2 + 2);
        exp_reply(8'h5A, -1, 1);
        drop_valid();
        wait_cyc(10);
        check("overrun_still_clear", 32'(bus_if.overrun), 32'd0);
        cfg_echo = 1'b0;

        // 'd' 0x01 with bdm_ready never returning: '!' after 16 WAIT_DONE cycles
        cfg_work  = -1;
        cfg_valid = 1'b0;
        wait_cyc(1);
        drive_byte(8'h64, j1);
        drop_valid();
        drive_byte(8'h01, j2);
        exp_strobe(V_DELAY, 8'h01, 1'b1, j2 + 2);
        exp_reply(8'h21, j2 + 19, -1);
        drop_valid();
        wait_cyc(19);
        check("timeout_back_idle", 32'(bus_if.busy), 32'd0);
        cfg_work = 3;
        wait_cyc(3);

        // 'x' then 's' during WAIT_DONE, then reset mid-command
        cfg_work = -1;
        wait_cyc(1);
        drive_byte(8'h78, j);
        exp_strobe(V_STOP, 8'h00, 1'b0, j + 2);
        drop_valid();
        wait_cyc(3);
        drive_byte(8'h73, j1);
        drop_valid();
        check("overrun_set", 32'(bus_if.overrun), 32'd1);
        check("busy_in_wait", 32'(bus_if.busy), 32'd1);
        wait_cyc(1);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        check("rst_mid_overrun", 32'(bus_if.overrun), 32'd0);
        check("rst_mid_busy", 32'(bus_if.busy), 32'd0);
        check("rst_mid_tx_data", 32'(bus_if.tx_data), 32'h00);
        cfg_work = 3;
        wait_cyc(25);

        // Stray byte arrives in the completion cycle of 'e' 0xC7
        cfg_echo  = 1'b1;
        cfg_valid = 1'b1;
        wait_cyc(1);
        drive_byte(8'h65, j1);
        drop_valid();
        drive_byte(8'hC7, j2);
        exp_strobe(V_ECHO, 8'hC7, 1'b1, j2 + 2);
        exp_reply(8'hC7, j2 + 6, 1);
        drop_valid();
        wait_cyc(3);
        drive_byte(8'h55, j);
        drop_valid();
        check("overrun_on_completion", 32'(bus_if.overrun), 32'd1);
        cfg_echo = 1'b0;
        wait_cyc(8);

        check("strobe_queue_drained", sb_strobe.size(), 32'd0);
        check("reply_queue_drained", sb_reply.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
